// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory port arbiter
//
// Purpose: state encoding, owner identifiers and counter width used by
//          mem_port_arbiter and rr_arbiter2.
// Ports:   none (package).
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way grant logic for the CPU and debug memory requesters
//
// Purpose: picks the owner of the next memory access. Round-robin on a tie by
//          default; with MEM_ARB_FIXED_PRIO_EN defined the CPU always wins a tie
//          and no history is kept.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   cpu_req_i    in   CPU request
//   dbg_req_i    in   debug-port request
//   grant_en_i   in   arbiter is allowed to grant this cycle (parent is idle)
//   gnt_valid_o  out  at least one requester is asking
//   gnt_owner_o  out  winning owner (OWN_CPU / OWN_DBG)
module rr_arbiter2
  import mips_mem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic grant_en_i,
  output logic gnt_valid_o,
  output logic gnt_owner_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // No grant history is needed when the CPU always wins.
  logic unused_fixed_prio;
  assign unused_fixed_prio = clock ^ reset ^ grant_en_i;

  always_comb begin
    gnt_valid_o = cpu_req_i | dbg_req_i;
    gnt_owner_o = cpu_req_i ? OWN_CPU : OWN_DBG;
  end
`else
  logic last_q, last_d;

  always_comb begin
    gnt_valid_o = cpu_req_i | dbg_req_i;
    last_d      = last_q;
    // On a tie the port that did not win last time gets the grant.
    if (cpu_req_i && dbg_req_i) begin
      gnt_owner_o = ~last_q;
    end else begin
      gnt_owner_o = cpu_req_i ? OWN_CPU : OWN_DBG;
    end
    if (grant_en_i && gnt_valid_o) begin
      last_d = gnt_owner_o;
    end
  end

  // Reset to DBG so the CPU takes the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWN_DBG;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port data memory between CPU and debug requesters
//
// Purpose: registers the winning command, strobes the memory for one cycle,
//          waits MEM_LAT cycles, captures read data and pulses the owner's ready.
//          Optional build macro: MEM_ARB_FIXED_PRIO_EN (CPU always wins ties).
//          MEM_LAT must be in 1..7.
// Ports:
//   clock, reset                         clock and synchronous active-high reset
//   cpu_req/we/addr/wdata  in            CPU command, held until cpu_ready
//   cpu_rdata, cpu_ready   out           CPU read data (held) and completion pulse
//   cpu_stall              out           cpu_req & ~cpu_ready
//   dbg_*                                same set for the debug/loader port
//   mem_addr/wdata/we/re   out           registered memory command and strobes
//   mem_rdata              in            memory data, valid MEM_LAT cycles after mem_re
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              dbg_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              owner_we_q, owner_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_en, gnt_valid, gnt_owner;

  assign grant_en = (state_q == ARB_IDLE);

  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .cpu_req_i   (cpu_req),
    .dbg_req_i   (dbg_req),
    .grant_en_i  (grant_en),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_we_d  = owner_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cnt_d       = cnt_q;
    // Strobes are registered: set on the grant edge so they are high
    // exactly during the ACCESS cycle, and cleared on every other edge.
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_owner;
          if (gnt_owner == OWN_CPU) begin
            owner_we_d = cpu_we;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
          end else begin
            owner_we_d = dbg_we;
            addr_d     = dbg_addr;
            wdata_d    = dbg_wdata;
          end
          mem_we_d = owner_we_d;
          mem_re_d = ~owner_we_d;
          state_d  = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          // Writes complete with the same timing but leave rdata untouched.
          if (!owner_we_q) begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_d = mem_rdata;
            end else begin
              dbg_rdata_d = mem_rdata;
            end
          end
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_CPU;
      owner_we_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_we_q  <= owner_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ready = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
  assign dbg_ready = (state_q == ARB_DONE) && (owner_q == OWN_DBG);
  assign cpu_stall = cpu_req & ~cpu_ready;
  assign dbg_stall = dbg_req & ~dbg_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at MEM_LAT 1 and 3
module tb_mem_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Instance 0: MEM_LAT = 1, instance 1: MEM_LAT = 3
  logic        c0_req = 0, c0_we = 0, d0_req = 0, d0_we = 0;
  logic [31:0] c0_addr = 0, c0_wdata = 0, d0_addr = 0, d0_wdata = 0;
  logic [31:0] c0_rdata, d0_rdata, m0_addr, m0_wdata, m0_rdata;
  logic        c0_ready, c0_stall, d0_ready, d0_stall, m0_we, m0_re;

  logic        c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [31:0] c1_addr = 0, c1_wdata = 0, d1_addr = 0, d1_wdata = 0;
  logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        c1_ready, c1_stall, d1_ready, d1_stall, m1_we, m1_re;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(c0_req), .cpu_we(c0_we), .cpu_addr(c0_addr), .cpu_wdata(c0_wdata),
    .cpu_rdata(c0_rdata), .cpu_ready(c0_ready), .cpu_stall(c0_stall),
    .dbg_req(d0_req), .dbg_we(d0_we), .dbg_addr(d0_addr), .dbg_wdata(d0_wdata),
    .dbg_rdata(d0_rdata), .dbg_ready(d0_ready), .dbg_stall(d0_stall),
    .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we), .mem_re(m0_re),
    .mem_rdata(m0_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_rdata(c1_rdata), .cpu_ready(c1_ready), .cpu_stall(c1_stall),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .dbg_rdata(d1_rdata), .dbg_ready(d1_ready), .dbg_stall(d1_stall),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_re(m1_re),
    .mem_rdata(m1_rdata)
  );

  // Memory models: read data is only valid in the exact cycle MEM_LAT after
  // the strobe; every other cycle shows JUNK.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic        pv0 = 1'b0;
  logic [31:0] pd0 = 32'h0;
  logic [2:0]  pv1 = 3'b000;
  logic [31:0] pd1 [3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'hC0DE_0000 | 32'(i);
      mem1[i] = 32'hC0DE_0000 | 32'(i);
    end
    mem0[8'h10] = 32'hDEAD_BEEF;
  end

  always @(posedge clock) begin
    pd0 <= mem0[m0_addr[7:0]];
    pv0 <= m0_re;
    if (m0_we) mem0[m0_addr[7:0]] = m0_wdata;
    pv1    <= {pv1[1:0], m1_re};
    pd1[0] <= mem1[m1_addr[7:0]];
    pd1[1] <= pd1[0];
    pd1[2] <= pd1[1];
  end

  assign m0_rdata = pv0 ? pd0 : JUNK;
  assign m1_rdata = pv1[2] ? pd1[2] : JUNK;

  typedef struct { bit port; logic [31:0] data; int cyc; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } stb_t;
  rsp_t rq0[$];
  rsp_t rq1[$];
  stb_t sq0[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_rsp(input int k, input logic cr, input logic dr,
                         input logic [31:0] crd, input logic [31:0] drd);
    rsp_t e;
    check($sformatf("ready_excl%0d", k), 32'(cr & dr), 32'h0);
    if ((k == 0 && rq0.size() == 0) || (k == 1 && rq1.size() == 0)) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_ready%0d: got cpu=%b dbg=%b expected none", k, cr, dr);
    end else begin
      e = (k == 0) ? rq0.pop_front() : rq1.pop_front();
      check($sformatf("ready_port%0d", k), 32'(dr), 32'(e.port));
      check($sformatf("ready_cycle%0d", k), 32'(cyc), 32'(e.cyc));
      check($sformatf("rdata%0d", k), e.port ? drd : crd, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (c0_ready === 1'b1 || d0_ready === 1'b1) mon_rsp(0, c0_ready, d0_ready, c0_rdata, d0_rdata);
    if (c1_ready === 1'b1 || d1_ready === 1'b1) mon_rsp(1, c1_ready, d1_ready, c1_rdata, d1_rdata);
  end

  always @(negedge clock) begin
    stb_t s;
    if (m0_we === 1'b1 || m0_re === 1'b1) begin
      check("strobe_excl", 32'(m0_we & m0_re), 32'h0);
      if (sq0.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got we=%b re=%b addr=%h expected none", m0_we, m0_re, m0_addr);
      end else begin
        s = sq0.pop_front();
        check("strobe_we", 32'(m0_we), 32'(s.we));
        check("strobe_cycle", 32'(cyc), 32'(s.cyc));
        check("strobe_addr", m0_addr, s.addr);
        if (s.we) check("strobe_wdata", m0_wdata, s.wdata);
      end
    end
  end

  // One access on instance k, started in an IDLE cycle; req is dropped at
  // the start of the DONE cycle so it is not taken as a new request.
  task automatic access(input int k, input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int n;
    int lat;
    lat = (k == 0) ? 1 : 3;
    @(posedge clock); #1;
    n = cyc;
    if (k == 0) begin
      if (port) begin d0_req = 1; d0_we = we; d0_addr = addr; d0_wdata = wdata; end
      else      begin c0_req = 1; c0_we = we; c0_addr = addr; c0_wdata = wdata; end
      rq0.push_back('{port, exp_rdata, n + 2 + lat});
      sq0.push_back('{we, addr, wdata, n + 1});
    end else begin
      if (port) begin d1_req = 1; d1_we = we; d1_addr = addr; d1_wdata = wdata; end
      else      begin c1_req = 1; c1_we = we; c1_addr = addr; c1_wdata = wdata; end
      rq1.push_back('{port, exp_rdata, n + 2 + lat});
    end
    for (int i = 0; i < 2 + lat; i++) begin
      if (i > 0) @(posedge clock);
      #2;
      if (k == 0) check("stall0", 32'(port ? d0_stall : c0_stall), 32'h1);
      else        check("stall1", 32'(port ? d1_stall : c1_stall), 32'h1);
    end
    @(posedge clock); #1;
    if (k == 0) begin c0_req = 0; d0_req = 0; end
    else        begin c1_req = 0; d1_req = 0; end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("rst_c0_rdata", c0_rdata, 32'h0);
    check("rst_d0_rdata", d0_rdata, 32'h0);
    check("rst_ready0", 32'({c0_ready, d0_ready}), 32'h0);
    check("rst_strobes0", 32'({m0_we, m0_re}), 32'h0);
    check("rst_mem_addr0", m0_addr, 32'h0);
    check("rst_mem_wdata0", m0_wdata, 32'h0);
    check("rst_stall0", 32'({c0_stall, d0_stall}), 32'h0);
    check("rst_c1_rdata", c1_rdata, 32'h0);
    check("rst_strobes1", 32'({m1_we, m1_re}), 32'h0);
    reset = 0;

    // MEM_LAT=3 read: ready at cycle 5, data only valid in the last WAIT cycle
    access(1, 1'b0, 1'b0, 32'h20, 32'h0, 32'hC0DE_0020);

    // Reset during WAIT: no ready, rdata cleared
    @(posedge clock); #1;
    n = cyc;
    c1_req = 1; c1_we = 0; c1_addr = 32'h30;
    repeat (3) @(posedge clock);
    #1;
    c1_req = 0;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    #1;
    check("rstmid_cycle", 32'(cyc), 32'(n + 4));
    check("rstmid_ready", 32'({c1_ready, d1_ready}), 32'h0);
    check("rstmid_rdata", c1_rdata, 32'h0);
    check("rstmid_strobe", 32'({m1_we, m1_re}), 32'h0);
    access(1, 1'b0, 1'b0, 32'h24, 32'h0, 32'hC0DE_0024);

    // Simultaneous requests right after reset, both held
    @(posedge clock); #1;
    n = cyc;
    c0_req = 1; c0_we = 0; c0_addr = 32'h10;
    d0_req = 1; d0_we = 0; d0_addr = 32'h14;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{1'b0, 32'hDEAD_BEEF, n + 3 + 4 * i});
      sq0.push_back('{1'b0, 32'h10, 32'h0, n + 1 + 4 * i});
    end
    rq0.push_back('{1'b1, 32'hC0DE_0014, n + 19});
    sq0.push_back('{1'b0, 32'h14, 32'h0, n + 17});
`else
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{i[0], i[0] ? 32'hC0DE_0014 : 32'hDEAD_BEEF, n + 3 + 4 * i});
      sq0.push_back('{1'b0, i[0] ? 32'h14 : 32'h10, 32'h0, n + 1 + 4 * i});
    end
`endif
    repeat (15) @(posedge clock);
    #1;
    c0_req = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    repeat (4) @(posedge clock);
    #1;
`endif
    d0_req = 0;

    // Debug write leaves dbg_rdata as it was
    access(0, 1'b1, 1'b1, 32'h4, 32'h55, 32'hC0DE_0014);
    access(0, 1'b0, 1'b0, 32'h4, 32'h0, 32'h55);
    access(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h55);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

    // Debug req that drops before it can be granted is ignored
    @(posedge clock); #1;
    n = cyc;
    c0_req = 1; c0_we = 0; c0_addr = 32'h4;
    rq0.push_back('{1'b0, 32'h55, n + 3});
    sq0.push_back('{1'b0, 32'h4, 32'h0, n + 1});
    @(posedge clock); #1;
    d0_req = 1; d0_we = 0; d0_addr = 32'h30;
    @(posedge clock); #1;
    d0_req = 0;
    @(posedge clock); #1;
    c0_req = 0;

    repeat (8) @(posedge clock);
    #1;
    check("pending_rsp0", 32'(rq0.size()), 32'h0);
    check("pending_rsp1", 32'(rq1.size()), 32'h0);
    check("pending_strobe0", 32'(sq0.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
